// File: rtl/l2_instr_mem_responder.sv
// l2_instr_mem_responder: stub L2 instruction memory that answers line-fill requests on the common bus.
// A side-band preload port fills the memory, and the bus is driven only while a response is presented.
module l2_instr_mem_responder #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_DEPTH_LOG2 = 10,
    parameter int READ_LATENCY   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      Com_Bus_Gnt,
    input  logic [ADDR_WIDTH-1:0]     Address_Com,
    inout  wire  [DATA_WIDTH-1:0]     Data_Bus_Com,
    inout  wire                       Data_in_Bus,
    input  logic                      Mem_wr_en,
    input  logic [MEM_DEPTH_LOG2-1:0] Mem_wr_addr,
    input  logic [DATA_WIDTH-1:0]     Mem_wr_data,
    output logic                      Busy
);
    typedef enum logic [1:0] {IDLE, ADDR, WAIT, RESP} state_t;
    state_t                    state;
    logic [3:0]                cnt;
    logic [MEM_DEPTH_LOG2-1:0] idx;
    logic [DATA_WIDTH-1:0]     resp;
    logic [DATA_WIDTH-1:0]     mem [2**MEM_DEPTH_LOG2];
    logic                      unused_addr_bits;

    // upper address bits wrap and the byte offset is always 00
    assign unused_addr_bits = ^{Address_Com[ADDR_WIDTH-1:MEM_DEPTH_LOG2+2], Address_Com[1:0]};
    assign Busy             = state != IDLE;
    assign Data_Bus_Com     = state == RESP ? resp : 'z;
    assign Data_in_Bus      = state == RESP ? 1'b1 : 1'bz;

    always_ff @(posedge clk)
        if (Mem_wr_en) mem[Mem_wr_addr] <= Mem_wr_data;

    // a low grant in any state aborts or completes the transaction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            resp  <= '0;
        end else if (!Com_Bus_Gnt) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: state <= ADDR;
                ADDR: begin
                    idx   <= Address_Com[MEM_DEPTH_LOG2+1:2];
                    cnt   <= 4'(READ_LATENCY);
                    state <= WAIT;
                end
                WAIT: if (cnt == 4'd1) begin
                    resp  <= mem[idx];
                    state <= RESP;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                default: state <= RESP;
            endcase
        end
    end
endmodule

// File: tb/tb_l2_instr_mem_responder.sv
// tb_l2_instr_mem_responder: directed requests checked against a transaction-level model every cycle,
// plus literal expectations at the key response cycles.
module tb_l2_instr_mem_responder;
    localparam int L = 4;
    logic        clk, rst, gnt, wr_en, busy;
    logic [31:0] addr, wr_data;
    logic [9:0]  wr_addr;
    wire  [31:0] data_bus;
    wire         data_in_bus;
    int          checks, failures;
    // model: run = consecutive granted edges of the current transaction
    int          run;
    logic [9:0]  m_idx;
    logic [31:0] m_data;
    logic [31:0] mm [1024];

    l2_instr_mem_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH_LOG2(10), .READ_LATENCY(L)) dut (
        .clk(clk), .rst(rst), .Com_Bus_Gnt(gnt), .Address_Com(addr),
        .Data_Bus_Com(data_bus), .Data_in_Bus(data_in_bus),
        .Mem_wr_en(wr_en), .Mem_wr_addr(wr_addr), .Mem_wr_data(wr_data), .Busy(busy)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
        end
    endtask

    // a released bus reads Z on a 4-state simulator and 0 on a 2-state one
    task automatic chk_rel(input string name);
        checks++;
        if (!(($isunknown(data_bus) || data_bus == 32'h0) && ($isunknown(data_in_bus) || data_in_bus == 1'b0))) begin
            failures++;
            $display("FAIL %s t=%0t got data=%h valid=%b exp=released", name, $time, data_bus, data_in_bus);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            run = 0;
        end else begin
            if (gnt) begin
                run++;
                if (run == 2) m_idx = addr[11:2];
                if (run == L + 2) m_data = mm[m_idx];
            end else begin
                run = 0;
            end
            if (wr_en) mm[wr_addr] = wr_data;
        end
    end

    always @(negedge clk) begin
        chk("model_busy", {31'b0, busy}, {31'b0, run > 0});
        if (run >= L + 2) begin
            chk("model_valid", {31'b0, data_in_bus}, 32'h1);
            chk("model_data", data_bus, m_data);
        end else begin
            chk_rel("model_released");
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic pre(input logic [9:0] a, input logic [31:0] d);
        wr_en = 1; wr_addr = a; wr_data = d;
        step(1);
        wr_en = 0;
    endtask

    // grant before edge 0, address from cycle 1, return just after edge 5
    task automatic req_to_resp(input logic [31:0] a);
        gnt = 1;
        step(1);
        addr = a;
        step(5);
    endtask

    initial begin
        checks = 0; failures = 0; run = 0;
        for (int i = 0; i < 1024; i++) mm[i] = '0;
        rst = 1; gnt = 0; wr_en = 0; addr = '0; wr_addr = '0; wr_data = '0;
        step(2);
        chk("reset_busy", {31'b0, busy}, 32'h0);
        chk_rel("reset_released");
        rst = 0;
        pre(10'h005, 32'hDEADBEEF);
        pre(10'h001, 32'h0000000A);
        pre(10'h002, 32'h0000000B);
        step(1);

        // basic read: response first at cycle 5, released after grant drops
        gnt = 1;
        step(1);
        addr = 32'h14;
        step(4);
        chk_rel("t1_not_yet_cycle4");
        step(1);
        chk("t1_valid", {31'b0, data_in_bus}, 32'h1);
        chk("t1_data", data_bus, 32'hDEADBEEF);
        step(1);
        chk("t1_held", data_bus, 32'hDEADBEEF);
        gnt = 0;
        step(1);
        chk("t1_busy_after", {31'b0, busy}, 32'h0);
        chk_rel("t1_released");

        // abort during WAIT
        gnt = 1;
        step(1);
        addr = 32'h14;
        step(3);
        gnt = 0;
        step(1);
        chk("t2_busy_cycle4", {31'b0, busy}, 32'h0);
        step(4);
        chk_rel("t2_released");

        // address wraps modulo memory size
        req_to_resp(32'h1014);
        chk("t3_wrap", data_bus, 32'hDEADBEEF);
        gnt = 0;
        step(1);

        // preload at edge 3 is visible
        gnt = 1;
        step(1);
        addr = 32'h14;
        step(2);
        wr_en = 1; wr_addr = 10'h005; wr_data = 32'h12345678;
        step(1);
        wr_en = 0;
        step(2);
        chk("t4_early_write", data_bus, 32'h12345678);
        gnt = 0;
        step(1);
        pre(10'h005, 32'hDEADBEEF);

        // preload on the capture edge returns old data
        gnt = 1;
        step(1);
        addr = 32'h14;
        step(4);
        wr_en = 1; wr_addr = 10'h005; wr_data = 32'h12345678;
        step(1);
        wr_en = 0;
        chk("t4_capture_edge", data_bus, 32'hDEADBEEF);
        gnt = 0;
        step(1);
        pre(10'h005, 32'hDEADBEEF);

        // async reset while in RESP
        req_to_resp(32'h14);
        chk("t5_pre_reset", data_bus, 32'hDEADBEEF);
        #2 rst = 1;
        #1;
        chk("t5_busy", {31'b0, busy}, 32'h0);
        chk_rel("t5_released_async");
        @(negedge clk);
        gnt = 0; rst = 0;
        step(1);
        req_to_resp(32'h14);
        chk("t5_mem_kept", data_bus, 32'hDEADBEEF);
        gnt = 0;
        step(1);

        // back-to-back with a one-cycle gap
        req_to_resp(32'h4);
        chk("t6_first", data_bus, 32'h0000000A);
        gnt = 0;
        step(1);
        req_to_resp(32'h8);
        chk("t6_second", data_bus, 32'h0000000B);
        gnt = 0;
        step(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
